fetch_pc_predictor: RTL and testbench

//  IF-stage next-PC generator that consumes the BTB lookup (hit, target) for current_pc.

---
 rtl/fetch_pc_predictor_pkg.sv | 28 ++
 rtl/fetch_pc_predictor_sat_counter2.sv | 34 +++
 rtl/fetch_pc_predictor.sv | 190 +++++++++++++++++++
 tb/tb_fetch_pc_predictor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_predictor_pkg
// Description : Shared definitions for the fetch-stage branch predictors.
//               - Default pattern-history-table index width.
//               - 2-bit saturating counter encodings.
//               - Predictor table initialisation FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_predictor_pkg;

  // Default log2 of the number of direction counters (also the GHR width).
  localparam int c_PHT_BITS = 5;

  // 2-bit saturating counter encodings. The MSB is the predicted direction.
  localparam logic [1:0] c_CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] c_CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] c_CNT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] c_CNT_ST  = 2'b11;  // strongly taken

  // Table initialisation FSM.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,  // walking the table, writing weak not-taken
    ST_RUN  = 1'b1   // normal fetch
  } state_e;

endpackage : fetch_pc_predictor_pkg
`default_nettype wire

// File: rtl/fetch_pc_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Combinational 2-bit saturating up/down counter step.
//               inc=1 moves towards strongly-taken and stops at 2'b11;
//               inc=0 moves towards strongly-not-taken and stops at 2'b00.
// Ports       : count_in  [1:0] in  current counter value
//               inc             in  1 = increment, 0 = decrement
//               count_out [1:0] out updated counter value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
  import fetch_pc_predictor_pkg::*;
(
  input  logic [1:0] count_in,
  input  logic       inc,
  output logic [1:0] count_out
);

  always_comb begin
    count_out = count_in;
    if (inc) begin
      if (count_in != c_CNT_ST) begin
        count_out = count_in + 2'd1;
      end
    end else begin
      if (count_in != c_CNT_SNT) begin
        count_out = count_in - 2'd1;
      end
    end
  end

endmodule : sat_counter2
`default_nettype wire

// File: rtl/fetch_pc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_predictor
// Description : IF-stage next-PC generator with a gshare direction predictor.
//               The BTB supplies hit/target for current_pc; a table of 2-bit
//               counters indexed by (PC ^ GHR) supplies the direction. A
//               speculative global history register shifts on BTB hits and is
//               repaired from the snapshot carried by a mispredicted branch.
//               After reset the counter table is walked once (one entry per
//               cycle) to weak not-taken before fetch starts.
// Ports       : clk, reset                 clock, synchronous active-high reset
//               stall                      hold PC and GHR
//               btb_hit, btb_target[31:0]  BTB lookup result for current_pc
//               resolve_valid/pc/ghr/taken resolved conditional branch (train)
//               mispredict, correct_pc     EX-stage redirect
//               current_pc[31:0]           PC being fetched
//               fetch_valid                low while the table initialises
//               pred_taken                 direction prediction for current_pc
//               pred_ghr[PHT_BITS-1:0]     history used for that prediction
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_predictor
  import fetch_pc_predictor_pkg::*;
#(
  parameter int          PHT_BITS = c_PHT_BITS,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                btb_hit,
  input  logic [31:0]         btb_target,
  input  logic                resolve_valid,
  input  logic [31:0]         resolve_pc,
  input  logic [PHT_BITS-1:0] resolve_ghr,
  input  logic                resolve_taken,
  input  logic                mispredict,
  input  logic [31:0]         correct_pc,
  output logic [31:0]         current_pc,
  output logic                fetch_valid,
  output logic                pred_taken,
  output logic [PHT_BITS-1:0] pred_ghr
);

  localparam int c_ENTRIES = 1 << PHT_BITS;
  localparam logic [PHT_BITS-1:0] c_LAST_IDX = {PHT_BITS{1'b1}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              r_state;
  state_e              w_state_next;
  logic [PHT_BITS-1:0] r_clr_idx;
  logic [31:0]         r_pc;
  logic [PHT_BITS-1:0] r_ghr;
  logic [1:0]          r_pht [c_ENTRIES];

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                w_run;
  logic [PHT_BITS-1:0] w_idx;
  logic [PHT_BITS-1:0] w_uidx;
  logic                w_pred_taken;
  logic [1:0]          w_upd_cnt;
  logic [31:0]         w_pc_next;
  logic [PHT_BITS-1:0] w_ghr_next;
  logic                w_pht_we;
  logic [PHT_BITS-1:0] w_pht_waddr;
  logic [1:0]          w_pht_wdata;
  logic                w_unused_bits;

  assign w_run = (r_state == ST_RUN);

  // gshare indexing: word-aligned PC bits folded with global history.
  assign w_idx  = r_pc[PHT_BITS+1:2] ^ r_ghr;
  assign w_uidx = resolve_pc[PHT_BITS+1:2] ^ resolve_ghr;

  // Predictions are suppressed while the table still holds stale contents.
  assign w_pred_taken = w_run & btb_hit & r_pht[w_idx][1];

  // Only the index bits of the resolved PC participate in training.
  assign w_unused_bits = &{1'b0, resolve_pc[31:PHT_BITS+2], resolve_pc[1:0]};

  // Training step for the entry addressed by the resolved branch.
  sat_counter2 u_sat_counter2 (
    .count_in  (r_pht[w_uidx]),
    .inc       (resolve_taken),
    .count_out (w_upd_cnt)
  );

  // --------------------------------------------------------------------------
  // Initialisation FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_clr_idx == c_LAST_IDX) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next PC and speculative history
  // --------------------------------------------------------------------------
  // A redirect outranks a stall so that the corrected path is never dropped.
  // History only shifts on fetches the BTB recognises as branches.
  always_comb begin
    w_pc_next  = r_pc;
    w_ghr_next = r_ghr;
    if (w_run) begin
      if (mispredict) begin
        w_pc_next  = correct_pc;
        w_ghr_next = {resolve_ghr[PHT_BITS-2:0], resolve_taken};
      end else if (!stall) begin
        w_pc_next = w_pred_taken ? btb_target : (r_pc + 32'd4);
        if (btb_hit) begin
          w_ghr_next = {r_ghr[PHT_BITS-2:0], w_pred_taken};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_ghr <= '0;
    end else begin
      r_pc  <= w_pc_next;
      r_ghr <= w_ghr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Counter table: single write port shared by initialisation and training
  // --------------------------------------------------------------------------
  always_comb begin
    w_pht_we    = 1'b0;
    w_pht_waddr = w_uidx;
    w_pht_wdata = w_upd_cnt;
    if (!reset) begin
      if (r_state == ST_INIT) begin
        w_pht_we    = 1'b1;
        w_pht_waddr = r_clr_idx;
        w_pht_wdata = c_CNT_WNT;
      end else if (resolve_valid) begin
        w_pht_we = 1'b1;
      end
    end
  end

  // No reset on the array itself: the INIT walk establishes its contents.
  // Reads in the same cycle see the pre-update value.
  always_ff @(posedge clk) begin
    if (w_pht_we) begin
      r_pht[w_pht_waddr] <= w_pht_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign current_pc  = r_pc;
  assign fetch_valid = w_run;
  assign pred_taken  = w_pred_taken;
  assign pred_ghr    = r_ghr;

endmodule : fetch_pc_predictor
`default_nettype wire

// File: tb/tb_fetch_pc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_predictor
// Description : Directed, table-driven bench for fetch_pc_predictor
//               (PHT_BITS=5, RESET_PC=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_predictor;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [4:0]  resolve_ghr;
  logic        resolve_taken;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] current_pc;
  logic        fetch_valid;
  logic        pred_taken;
  logic [4:0]  pred_ghr;

  int n_total;
  int n_pass;

  fetch_pc_predictor #(
    .PHT_BITS (5),
    .RESET_PC (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .btb_hit       (btb_hit),
    .btb_target    (btb_target),
    .resolve_valid (resolve_valid),
    .resolve_pc    (resolve_pc),
    .resolve_ghr   (resolve_ghr),
    .resolve_taken (resolve_taken),
    .mispredict    (mispredict),
    .correct_pc    (correct_pc),
    .current_pc    (current_pc),
    .fetch_valid   (fetch_valid),
    .pred_taken    (pred_taken),
    .pred_ghr      (pred_ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One fetch cycle: inputs, then expected same-cycle prediction/GHR and
  // the PC registered at the following edge.
  typedef struct {
    logic        stall;
    logic        hit;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rpc;
    logic [4:0]  rghr;
    logic        rt;
    logic        misp;
    logic [31:0] cpc;
    logic        e_pred;
    logic [4:0]  e_ghr;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic hit, input logic [31:0] tgt,
                              input logic rv, input logic [31:0] rpc, input logic [4:0] rghr,
                              input logic rt, input logic misp, input logic [31:0] cpc,
                              input logic e_pred, input logic [4:0] e_ghr,
                              input logic [31:0] e_pc);
    vec_t v;
    v.stall = st;  v.hit = hit;   v.tgt = tgt;
    v.rv = rv;     v.rpc = rpc;   v.rghr = rghr;  v.rt = rt;
    v.misp = misp; v.cpc = cpc;
    v.e_pred = e_pred; v.e_ghr = e_ghr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive_idle();
    stall = 1'b0; btb_hit = 1'b0; btb_target = '0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_ghr = '0; resolve_taken = 1'b0;
    mispredict = 1'b0; correct_pc = '0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    stall = v.stall; btb_hit = v.hit; btb_target = v.tgt;
    resolve_valid = v.rv; resolve_pc = v.rpc; resolve_ghr = v.rghr;
    resolve_taken = v.rt; mispredict = v.misp; correct_pc = v.cpc;
    #2;
    chk({nm, " pred_taken"}, {31'd0, pred_taken}, {31'd0, v.e_pred});
    chk({nm, " pred_ghr"}, {27'd0, pred_ghr}, {27'd0, v.e_ghr});
    @(posedge clk);
    #1;
    chk({nm, " next_pc"}, current_pc, v.e_pc);
  endtask

  // Counts edges until fetch_valid rises (bounded).
  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!fetch_valid && n < 100) begin
      chk({nm, " pc held"}, current_pc, 32'h0);
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " init cycles"}, n, 32);
  endtask

  vec_t vt[16];
  vec_t sq[14];

  initial begin
    n_total = 0;
    n_pass  = 0;
    drive_idle();
    reset = 1'b1;
    btb_hit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pc", current_pc, 32'h0);
    chk("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset pred_ghr", {27'd0, pred_ghr}, 32'd0);

    // INIT walk with redirect and training traffic that must be ignored.
    reset = 1'b0;
    mispredict = 1'b1; correct_pc = 32'h200;
    resolve_valid = 1'b1; resolve_pc = 32'h0; resolve_ghr = '0; resolve_taken = 1'b1;
    wait_init("init1");
    drive_idle();
    chk("init1 pc after", current_pc, 32'h0);

    //         st   hit  tgt           rv   rpc        rghr      rt   misp cpc           pred ghr    next pc
    vt[0]  = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h00, 32'h4);
    vt[1]  = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h00, 32'h8);
    vt[2]  = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h00, 32'hC);
    vt[3]  = mk(0, 1, 32'h500,      0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h00, 32'h10);
    vt[4]  = mk(0, 0, 32'h0,        1, 32'h40,  5'h00, 1, 0, 32'h0,        0, 5'h00, 32'h14);
    vt[5]  = mk(0, 0, 32'h0,        1, 32'h40,  5'h00, 1, 0, 32'h0,        0, 5'h00, 32'h18);
    vt[6]  = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 1, 32'h40,       0, 5'h00, 32'h40);
    vt[7]  = mk(0, 1, 32'h100,      0, 32'h0,   5'h00, 0, 0, 32'h0,        1, 5'h00, 32'h100);
    vt[8]  = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h01, 32'h104);
    vt[9]  = mk(1, 1, 32'h300,      0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h01, 32'h104);
    vt[10] = mk(1, 0, 32'h0,        1, 32'h18,  5'h06, 0, 1, 32'h200,      0, 5'h01, 32'h200);
    vt[11] = mk(0, 1, 32'h600,      0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h0C, 32'h204);
    vt[12] = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h18, 32'h208);
    vt[13] = mk(0, 1, 32'h700,      1, 32'h208, 5'h18, 1, 0, 32'h0,        0, 5'h18, 32'h20C);
    vt[14] = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 1, 32'hFFFFFFFC, 0, 5'h10, 32'hFFFFFFFC);
    vt[15] = mk(0, 0, 32'h0,        0, 32'h0,   5'h00, 0, 0, 32'h0,        0, 5'h00, 32'h0);
    for (int i = 0; i < 16; i++) begin
      run_vec(vt[i], $sformatf("vec%0d", i));
    end
    chk("ghr after mispredict+stall path", {27'd0, pred_ghr}, 32'd0);

    // Saturation on entry 0 (pc 0, ghr 0, counter at 00), PC held by stall.
    sq[0]  = mk(1, 0, 32'h0, 1, 32'h0, 5'h00, 0, 0, 32'h0, 0, 5'h00, 32'h0);
    sq[1]  = mk(1, 0, 32'h0, 1, 32'h0, 5'h00, 0, 0, 32'h0, 0, 5'h00, 32'h0);
    sq[2]  = mk(1, 0, 32'h0, 1, 32'h0, 5'h00, 0, 0, 32'h0, 0, 5'h00, 32'h0);
    sq[3]  = mk(1, 0, 32'h0, 1, 32'h0, 5'h00, 1, 0, 32'h0, 0, 5'h00, 32'h0);
    sq[4]  = mk(1, 1, 32'h0, 0, 32'h0, 5'h00, 0, 0, 32'h0, 0, 5'h00, 32'h0);
    sq[5]  = mk(1, 1, 32'h0, 1, 32'h0, 5'h00, 1, 0, 32'h0, 0, 5'h00, 32'h0);
    sq[6]  = mk(1, 1, 32'h0, 1, 32'h0, 5'h00, 1, 0, 32'h0, 1, 5'h00, 32'h0);
    sq[7]  = mk(1, 1, 32'h0, 1, 32'h0, 5'h00, 1, 0, 32'h0, 1, 5'h00, 32'h0);
    sq[8]  = mk(1, 1, 32'h0, 1, 32'h0, 5'h00, 1, 0, 32'h0, 1, 5'h00, 32'h0);
    sq[9]  = mk(1, 1, 32'h0, 1, 32'h0, 5'h00, 1, 0, 32'h0, 1, 5'h00, 32'h0);
    sq[10] = mk(1, 1, 32'h0, 1, 32'h0, 5'h00, 0, 0, 32'h0, 1, 5'h00, 32'h0);
    sq[11] = mk(1, 1, 32'h0, 0, 32'h0, 5'h00, 0, 0, 32'h0, 1, 5'h00, 32'h0);
    sq[12] = mk(1, 1, 32'h0, 1, 32'h0, 5'h00, 0, 0, 32'h0, 1, 5'h00, 32'h0);
    sq[13] = mk(1, 1, 32'h0, 0, 32'h0, 5'h00, 0, 0, 32'h0, 0, 5'h00, 32'h0);
    for (int i = 0; i < 14; i++) begin
      run_vec(sq[i], $sformatf("sat%0d", i));
    end

    // Reset in the middle of RUN.
    run_vec(mk(1, 0, 32'h0, 0, 32'h0, 5'h00, 0, 1, 32'h80, 0, 5'h00, 32'h80), "to_0x80");
    reset = 1'b1;
    mispredict = 1'b1; correct_pc = 32'h300;
    resolve_valid = 1'b1; resolve_pc = 32'h40; resolve_ghr = '0; resolve_taken = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun reset pc", current_pc, 32'h0);
    chk("midrun reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    reset = 1'b0;
    wait_init("init2");
    drive_idle();
    // Entry 0x10 was strongly taken before reset; it must be weak not-taken now.
    run_vec(mk(0, 0, 32'h0, 0, 32'h0, 5'h00, 0, 1, 32'h40, 0, 5'h00, 32'h40), "redir_0x40");
    run_vec(mk(0, 1, 32'h100, 0, 32'h0, 5'h00, 0, 0, 32'h0, 0, 5'h00, 32'h44), "post_reset_lookup");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fetch_pc_predictor
`default_nettype wire
